// File: rtl/mic_array_frontend.sv
// rtl/mic_array_frontend.sv - I2S mic array capture, block-average decimation, gain/saturate, valid/ready output
module mic_array_frontend #(
  parameter int CHANNELS    = 4,
  parameter int SCK_DIV     = 32,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 24,
  parameter int OUT_BITS    = 16,
  parameter int DECIM       = 2,
  parameter int SIDE        = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [CHANNELS-1:0]          mic_data,
  output logic                         mic_sck,
  output logic                         mic_ws,
  input  logic [3:0]                   gain_shift,
  input  logic                         audio_ready,
  output logic [CHANNELS*OUT_BITS-1:0] audio_data,
  output logic                         audio_valid,
  output logic                         overflow
);

  localparam int HALF  = SCK_DIV / 2;
  localparam int DW    = $clog2(SCK_DIV);
  localparam int BW    = $clog2(2 * SLOT_BITS);
  localparam int LOG2D = $clog2(DECIM);
  localparam int FW    = (LOG2D > 0) ? LOG2D : 1;
  localparam int AW    = SAMPLE_BITS + LOG2D;
  localparam int SW    = SAMPLE_BITS + 15;
  localparam int DROP  = SAMPLE_BITS - OUT_BITS;

  localparam logic [DW-1:0] HALF_L    = DW'(HALF);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCK_DIV - 1);
  localparam logic [BW-1:0] SLOT_L    = BW'(SLOT_BITS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SAMPLE_L  = BW'(SAMPLE_BITS);
  localparam logic [FW-1:0] FRAME_END = FW'(DECIM - 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (OUT_BITS - 1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic [DW-1:0] div_cnt, div_next;
  logic [BW-1:0] bit_cnt, bit_next, slot_pos;
  logic          fall_evt, rise_evt, in_slot, capture, last_bit;

  logic [SAMPLE_BITS-1:0]        shreg [CHANNELS];
  logic                          sample_stb;
  logic [FW-1:0]                 frame_cnt;
  logic signed [AW-1:0]          acc     [CHANNELS];
  logic signed [AW-1:0]          sum     [CHANNELS];
  logic signed [SAMPLE_BITS-1:0] avg     [CHANNELS];
  logic signed [SW-1:0]          scaled  [CHANNELS];
  logic signed [SW-1:0]          shifted [CHANNELS];
  logic [CHANNELS*OUT_BITS-1:0]  sat_packed;
  logic [CHANNELS*OUT_BITS-1:0]  res_data;
  logic                          res_valid;

  // Event decode: rise_evt is the first cycle with sck high, fall_evt the last cycle of an sck period
  always_comb begin
    fall_evt = (div_cnt == DIV_LAST);
    rise_evt = (div_cnt == HALF_L);
    div_next = fall_evt ? '0 : div_cnt + DW'(1);
    bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
    in_slot  = (SIDE != 0) ? (bit_cnt >= SLOT_L) : (bit_cnt < SLOT_L);
    slot_pos = (SIDE != 0) ? (bit_cnt - SLOT_L) : bit_cnt;
    capture  = rise_evt && in_slot && (slot_pos >= BW'(1)) && (slot_pos <= SAMPLE_L);
    last_bit = capture && (slot_pos == SAMPLE_L);
  end

  // Clock divider and bit counter; sck/ws are registered from the next-state counts
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      mic_sck <= 1'b0;
      mic_ws  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      mic_sck <= (div_next >= HALF_L);
      if (fall_evt) begin
        bit_cnt <= bit_next;
        mic_ws  <= (bit_next >= SLOT_L);
      end
    end
  end

  // Per-channel MSB-first deserialiser; strobe once the last data bit has been shifted in
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_stb <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) shreg[i] <= '0;
    end else begin
      sample_stb <= last_bit;
      if (capture) begin
        for (int i = 0; i < CHANNELS; i++) shreg[i] <= {shreg[i][SAMPLE_BITS-2:0], mic_data[i]};
      end
    end
  end

  // Block average, gain shift and saturation of the block result
  always_comb begin
    sat_packed = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]     = acc[i] + AW'($signed(shreg[i]));
      avg[i]     = SAMPLE_BITS'(sum[i] >>> LOG2D);
      scaled[i]  = SW'(avg[i]) <<< gain_shift;
      shifted[i] = scaled[i] >>> DROP;
      if (shifted[i] > SAT_MAX)
        sat_packed[i*OUT_BITS +: OUT_BITS] = SAT_MAX[OUT_BITS-1:0];
      else if (shifted[i] < SAT_MIN)
        sat_packed[i*OUT_BITS +: OUT_BITS] = SAT_MIN[OUT_BITS-1:0];
      else
        sat_packed[i*OUT_BITS +: OUT_BITS] = shifted[i][OUT_BITS-1:0];
    end
  end

  // Accumulate words across a block; register the scaled result on the block's last word
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_cnt <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      res_valid <= sample_stb && (frame_cnt == FRAME_END);
      if (sample_stb) begin
        if (frame_cnt == FRAME_END) begin
          frame_cnt <= '0;
          res_data  <= sat_packed;
          for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
          for (int i = 0; i < CHANNELS; i++) acc[i] <= sum[i];
        end
      end
    end
  end

  // Output holding register: load when free or being consumed, otherwise drop and flag overflow
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      audio_data  <= '0;
      audio_valid <= 1'b0;
      overflow    <= 1'b0;
    end else if (res_valid) begin
      if (!audio_valid || audio_ready) begin
        audio_data  <= res_data;
        audio_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (audio_ready) begin
      audio_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mic_array_frontend.sv
// tb/tb_mic_array_frontend.sv - self-checking bench for mic_array_frontend (DECIM=1 and DECIM=2 instances)
module tb_mic_array_frontend;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [3:0]  mic_data;
  logic [3:0]  gain_shift;
  logic        ready1, ready2;
  logic        sck1, ws1, valid1, ovf1;
  logic        sck2, ws2, valid2, ovf2;
  logic [63:0] data1, data2;

  int checks = 0;
  int errors = 0;
  int n;
  int gbase;
  bit sb1;

  logic [23:0] lw [0:63][0:3];
  logic [23:0] rw [0:63][0:3];
  logic [3:0]  gain_of [0:63];
  logic [63:0] q1 [$];
  logic [63:0] q2 [$];

  always #5 clk_in = ~clk_in;

  mic_array_frontend #(.CHANNELS(4), .SCK_DIV(4), .DECIM(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .mic_data(mic_data), .mic_sck(sck1), .mic_ws(ws1),
    .gain_shift(gain_shift), .audio_ready(ready1), .audio_data(data1),
    .audio_valid(valid1), .overflow(ovf1)
  );

  mic_array_frontend #(.CHANNELS(4), .SCK_DIV(4), .DECIM(2)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .mic_data(mic_data), .mic_sck(sck2), .mic_ws(ws2),
    .gain_shift(gain_shift), .audio_ready(ready2), .audio_data(data2),
    .audio_valid(valid2), .overflow(ovf2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [23:0] w);
    int v;
    v = int'(w);
    if (w[23]) v = v - 32'sh1000000;
    return v;
  endfunction

  // Integer model: multiply by 2^gain, floor-divide by 256, clamp to signed 16 bits
  function automatic logic [15:0] scale(input int avg, input int g);
    longint y;
    y = longint'(avg) * (longint'(1) << g);
    y = y >>> 8;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return 16'(y);
  endfunction

  function automatic logic [63:0] expect1(input int g);
    logic [63:0] e;
    for (int c = 0; c < 4; c++) e[c*16 +: 16] = scale(sx(lw[g][c]), int'(gain_of[g]));
    return e;
  endfunction

  function automatic logic [63:0] expect2(input int g);
    logic [63:0] e;
    int s;
    for (int c = 0; c < 4; c++) begin
      s = sx(lw[g-1][c]) + sx(lw[g][c]);
      e[c*16 +: 16] = scale(s >>> 1, int'(gain_of[g]));
    end
    return e;
  endfunction

  // Runs at each negedge: n = posedges since reset release
  task automatic check_and_drive();
    int k, r, g, b;
    k = n / 256;
    r = n % 256;
    g = gbase + k;
    b = (n / 4) % 64;
    if (n < 512) begin
      chk("sck1", 64'(sck1), 64'((n % 4) >= 2));
      chk("ws1",  64'(ws1),  64'(b >= 32));
      chk("sck2", 64'(sck2), 64'((n % 4) >= 2));
      chk("ws2",  64'(ws2),  64'(b >= 32));
    end
    if (sb1) begin
      if (r == 100) chk("valid1_early", 64'(valid1), 64'(0));
      if (r == 101) chk("valid1_lat",   64'(valid1), 64'(1));
      if (r == 102) chk("valid1_drop",  64'(valid1), 64'(0));
    end
    if (n % 512 == 356) chk("valid2_early", 64'(valid2), 64'(0));
    if (n % 512 == 357) chk("valid2_lat",   64'(valid2), 64'(1));
    if (sb1 && valid1 && ready1) begin
      chk("q1_size", 64'(q1.size()), 64'(1));
      if (q1.size() > 0) chk("data1", data1, q1.pop_front());
      if (g == 0) begin
        chk("f0_ch0", 64'(data1[15:0]),  64'(16'h1234));
        chk("f0_ch1", 64'(data1[31:16]), 64'(16'h0000));
        chk("f0_ch2", 64'(data1[47:32]), 64'(16'h0000));
        chk("f0_ch3", 64'(data1[63:48]), 64'(16'hFEDC));
      end
      if (g == 1) begin
        chk("sat_pos", 64'(data1[15:0]),  64'(16'h7FFF));
        chk("sat_neg", 64'(data1[31:16]), 64'(16'h8000));
        chk("gain2",   64'(data1[47:32]), 64'(16'h0040));
      end
    end
    if (valid2 && ready2) begin
      chk("q2_size", 64'(q2.size()), 64'(1));
      if (q2.size() > 0) chk("data2", data2, q2.pop_front());
      if (g == 3) chk("decim2_ch0", 64'(data2[15:0]), 64'(16'h0200));
    end
    gain_shift = gain_of[g];
    for (int c = 0; c < 4; c++) begin
      if (b >= 1 && b <= 24)       mic_data[c] = lw[g][c][24 - b];
      else if (b >= 33 && b <= 56) mic_data[c] = rw[g][c][56 - b];
      else                         mic_data[c] = 1'($urandom);
    end
    if (r == 98) begin
      if (sb1) q1.push_back(expect1(g));
      if (k % 2 == 1) q2.push_back(expect2(g));
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    n = n + 1;
    @(negedge clk_in);
    check_and_drive();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_sck1"},  64'(sck1),   64'(0));
    chk({tag, "_ws1"},   64'(ws1),    64'(0));
    chk({tag, "_vld1"},  64'(valid1), 64'(0));
    chk({tag, "_dat1"},  data1,       64'(0));
    chk({tag, "_ovf1"},  64'(ovf1),   64'(0));
    chk({tag, "_sck2"},  64'(sck2),   64'(0));
    chk({tag, "_vld2"},  64'(valid2), 64'(0));
    chk({tag, "_dat2"},  data2,       64'(0));
    chk({tag, "_ovf2"},  64'(ovf2),   64'(0));
  endtask

  initial begin
    for (int g = 0; g < 64; g++) begin
      for (int c = 0; c < 4; c++) begin
        lw[g][c] = 24'($urandom);
        rw[g][c] = 24'($urandom);
      end
      rw[g][0]   = 24'h7FFFFF;
      gain_of[g] = 4'($urandom_range(0, 15));
    end
    lw[0][0] = 24'h123456; lw[0][1] = 24'h000000; lw[0][2] = 24'h000000; lw[0][3] = 24'hFEDCBA;
    gain_of[0] = 4'd0;
    lw[1][0] = 24'h400000; lw[1][1] = 24'hC00000; lw[1][2] = 24'h001000;
    gain_of[1] = 4'd2;
    lw[2][0] = 24'h000100; lw[3][0] = 24'h000300;
    gain_of[2] = 4'd8; gain_of[3] = 4'd8;

    rst_in = 1'b1; ready1 = 1'b1; ready2 = 1'b1; mic_data = '0; gain_shift = '0;
    gbase = 0; sb1 = 1'b1; n = 0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_cleared("rst");
    rst_in = 1'b0;
    check_and_drive();

    while (n < 10 * 256) step();

    ready1 = 1'b0;
    sb1    = 1'b0;
    while (n < 10 * 256 + 101) step();
    chk("bp1_valid", 64'(valid1), 64'(1));
    chk("bp1_data",  data1, expect1(gbase + 10));
    chk("bp1_ovf",   64'(ovf1), 64'(0));
    while (n < 11 * 256 + 101) step();
    chk("bp2_valid", 64'(valid1), 64'(1));
    chk("bp2_data",  data1, expect1(gbase + 10));
    chk("bp2_ovf",   64'(ovf1), 64'(1));
    while (n < 12 * 256 + 101) step();
    chk("bp3_data",  data1, expect1(gbase + 10));
    chk("bp3_ovf",   64'(ovf1), 64'(1));
    while (n < 13 * 256 + 100) step();
    ready1 = 1'b1;
    step();
    chk("hs_load_valid", 64'(valid1), 64'(1));
    chk("hs_load_data",  data1, expect1(gbase + 13));
    step();
    chk("hs_drop_valid", 64'(valid1), 64'(0));

    while (n < 14 * 256) step();
    ready1 = 1'b0;
    while (n < 15 * 256 + 42) step();
    chk("pre_rst_valid", 64'(valid1), 64'(1));
    chk("pre_rst_ovf",   64'(ovf1),   64'(1));
    chk("pre_rst_sck",   64'(sck1),   64'(1));
    #2 rst_in = 1'b1;
    #1 chk_cleared("async");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_hold_sck", 64'(sck1), 64'(0));
    rst_in = 1'b0;
    gbase  = gbase + 16;
    n      = 0;
    q1.delete();
    q2.delete();
    ready1 = 1'b1;
    sb1    = 1'b1;
    check_and_drive();
    while (n < 4 * 256 + 10) step();
    chk("q1_drained", 64'(q1.size()), 64'(0));
    chk("q2_drained", 64'(q2.size()), 64'(0));
    chk("ovf2_clear", 64'(ovf2), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
